// File: rtl/switch_net_store.sv
// switch_net_store: clocked strength/level resolver for one dynamic net.
//
// Each clock the N_DRV driver words are resolved to the strongest level.
// When no driver is active the net keeps its last level as stored charge,
// reported at CHARGE_S strength, until DECAY_CYCLES undriven edges have
// elapsed. DECAY_CYCLES = 0 keeps the charge indefinitely.
//
// Word format: bit 0 = level (1 = high), bits [W-1:1] = strength (0 = off).
//
// Ports
//   clk       in   clock, all state updates on the rising edge
//   reset     in   synchronous, active-high reset
//   drv_in    in   N_DRV*W  driver words, driver i at [i*W +: W]
//   net_out   out  W        registered resolved net word
//   driven    out  1        some driver had strength > 0 at the last edge
//   conflict  out  1        strongest drivers disagreed on level at the last edge
//   floating  out  1        net holds neither drive nor charge

// Per-driver decode: splits the word and flags whether this driver is one
// of the strongest, and at which level.
module switch_net_lane #(
  parameter int unsigned W  = 4,
  parameter int unsigned SW = W - 1
) (
  input  logic [W-1:0]  drv,
  input  logic [SW-1:0] smax,
  output logic [SW-1:0] str,
  output logic          win_hi,
  output logic          win_lo
);
  logic is_win;

  assign str    = drv[W-1:1];
  // A lane at strength 0 never wins, even when nothing else drives.
  assign is_win = (smax != '0) && (str == smax);
  assign win_hi = is_win & drv[0];
  assign win_lo = is_win & ~drv[0];
endmodule

module switch_net_store #(
  parameter int unsigned      W            = 4,
  parameter int unsigned      N_DRV        = 4,
  parameter logic [W-2:0]     CHARGE_S     = 1,
  parameter int unsigned      DECAY_CYCLES = 16,
  parameter bit               TIE_MODE     = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_DRV*W-1:0] drv_in,
  output logic [W-1:0]       net_out,
  output logic               driven,
  output logic               conflict,
  output logic               floating
);
  localparam int unsigned SW    = W - 1;
  localparam logic [SW-1:0] S_OFF = '0;
  localparam logic          L_LO  = 1'b0;
  localparam int unsigned CW_RAW = $clog2(DECAY_CYCLES + 1);
  localparam int unsigned CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam bit            DECAY_EN = (DECAY_CYCLES != 0);
  localparam logic [CW-1:0] DECAY_LIM = DECAY_EN ? CW'(DECAY_CYCLES) : CNT_MAX;

  logic [N_DRV-1:0][SW-1:0] str;
  logic [N_DRV-1:0]         win_hi, win_lo;
  logic [SW-1:0]            smax;

  genvar g;
  generate
    for (g = 0; g < N_DRV; g++) begin : g_lane
      switch_net_lane #(.W(W), .SW(SW)) u_lane (
        .drv    (drv_in[g*W +: W]),
        .smax   (smax),
        .str    (str[g]),
        .win_hi (win_hi[g]),
        .win_lo (win_lo[g])
      );
    end
  endgenerate

  always_comb begin
    smax = S_OFF;
    for (int i = 0; i < N_DRV; i++)
      if (str[i] > smax) smax = str[i];
  end

  // Stored state
  logic          stored_lvl, charged;
  logic [CW-1:0] cnt;

  // Next-state values
  logic [W-1:0]  n_net;
  logic          n_driven, n_conf, n_float, n_stored, n_charged;
  logic [CW-1:0] n_cnt, cnt_inc;
  logic          tie, lvl;

  always_comb begin
    n_net     = {S_OFF, L_LO};
    n_driven  = 1'b0;
    n_conf    = 1'b0;
    n_float   = 1'b1;
    n_stored  = stored_lvl;
    n_charged = charged;
    n_cnt     = cnt;
    tie       = (|win_hi) & (|win_lo);
    lvl       = L_LO;
    cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

    if (smax != S_OFF) begin
      // Equal-strength disagreement: low wins, or hold the stored level.
      lvl       = tie ? (TIE_MODE ? stored_lvl : L_LO) : (|win_hi);
      n_net     = {smax, lvl};
      n_driven  = 1'b1;
      n_conf    = tie;
      n_float   = 1'b0;
      n_stored  = lvl;
      n_charged = 1'b1;
      n_cnt     = '0;
    end else if (charged) begin
      if (DECAY_EN && (cnt_inc >= DECAY_LIM)) begin
        // Charge has leaked away: net floats and forgets its level.
        n_charged = 1'b0;
        n_stored  = L_LO;
        n_cnt     = '0;
      end else begin
        n_net   = {CHARGE_S, stored_lvl};
        n_float = 1'b0;
        n_cnt   = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      net_out    <= {S_OFF, L_LO};
      driven     <= 1'b0;
      conflict   <= 1'b0;
      floating   <= 1'b1;
      stored_lvl <= L_LO;
      charged    <= 1'b0;
      cnt        <= '0;
    end else begin
      net_out    <= n_net;
      driven     <= n_driven;
      conflict   <= n_conf;
      floating   <= n_float;
      stored_lvl <= n_stored;
      charged    <= n_charged;
      cnt        <= n_cnt;
    end
  end
endmodule

// File: doc/switch_net_store.md
# switch_net_store

Parametrised, clocked successor to the combinational switch-level primitives: resolves up to `N_DRV` strength/level drivers onto one net each clock. When nothing drives the net it keeps its last level as stored charge, which decays after a programmable number of cycles. It is used for dynamic nodes (precharged buses, latch storage nodes) in extracted NMOS netlists, where the combinational transistor models cannot represent charge retention.

## Interface
Parameters:
- `W`, 4: signal word width; bit 0 = level (`L_HI`/`L_LO`), bits [3:1] = strength (`S_OFF` = 0, higher = stronger, `S_STRONG` maximum), per the shared header.
- `N_DRV`, 4: number of driver inputs, ≥1.
- `CHARGE_S`, 3'd1: strength reported while the net holds stored charge; must be >0 and below every driven strength used.
- `DECAY_CYCLES`, 16: consecutive undriven cycles before charge is lost; 0 = never decays.
- `TIE_MODE`, 0: level on equal-strength conflict; 0 = `L_LO` wins, 1 = keep previous stored level.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `drv_in`  in  `N_DRV*W`  driver words; driver i at [i*W +: W].
- `net_out`  out  `W`  registered resolved net word.
- `driven`  out  1  registered; 1 if any driver strength >0 at the last edge.
- `conflict`  out  1  registered; 1 if the last edge saw strongest drivers disagreeing on level.
- `floating`  out  1  registered; 1 when the net holds neither drive nor charge.

## Operation
- Reset (sampled high at an edge): `net_out`={`S_OFF`,`L_LO`}, `driven`=0, `conflict`=0, `floating`=1, stored level=`L_LO`, charged=0, decay counter=0. Reset overrides all inputs, including mid-decay.
- Per edge, compute `smax` = maximum strength over all drivers.
- Driven case (`smax`>0):
  - The winners are the drivers with strength == `smax`.
  - If all winners share a level, that level is used and `conflict`=0.
  - If winners disagree, `conflict`=1. Level is `L_LO` when `TIE_MODE`=0, or the current stored level when `TIE_MODE`=1.
  - Updates: `net_out`={`smax`, level}; stored level=level; charged=1; counter=0; `driven`=1; `floating`=0.
- Undriven case (`smax`=0), with `driven`=0 and `conflict`=0:
  - If charged=0: `net_out`={`S_OFF`,`L_LO`} and `floating`=1.
  - If charged=1: cnt_next = counter+1, saturating at counter max.
    - If `DECAY_CYCLES`≠0 and cnt_next ≥ `DECAY_CYCLES`: charged=0, `net_out`={`S_OFF`,`L_LO`}, `floating`=1, and stored level is reset to `L_LO`.
    - Otherwise: `net_out`={`CHARGE_S`, stored level}, `floating`=0, counter=cnt_next.
- Counter width is clog2(`DECAY_CYCLES`+1), minimum 1 bit. It never wraps.
- A driver at `CHARGE_S` strength counts as driven. Stored charge never competes with drivers; any drive >0 replaces it.

## Timing
- Latency: 1 cycle. Outputs reflect `drv_in` sampled at the previous rising edge. There is no combinational path from input to output.
- Resolution is fully combinational within one cycle for any `N_DRV`; there is no multi-cycle iteration.
- Decay sequence after the last driven edge, with `DECAY_CYCLES`=D≥1: undriven edges 1..D-1 show `CHARGE_S`; edge D shows `S_OFF`/`floating`=1. With D=1, the net floats on the first undriven edge.
- Re-drive during decay: the counter clears on that edge and the drive value appears next cycle.
- Reset and drive in the same cycle: reset wins; the drive is observed from the following edge only.

## Test plan
- Reset, then `drv_in` all `S_OFF` for 3 edges -> `net_out`={`S_OFF`,`L_LO`}, `floating`=1, `driven`=0 throughout.
- Driver0={`S_STRONG`,`L_HI`}, driver1={3'd5,`L_LO`} -> one edge later `net_out`={`S_STRONG`,`L_HI`}, `conflict`=0, `driven`=1.
- Driver0={3'd5,`L_HI`}, driver2={3'd5,`L_LO`}:
  - `TIE_MODE`=0 -> `net_out`={3'd5,`L_LO`}, `conflict`=1.
  - `TIE_MODE`=1 with prior stored `L_HI` -> {3'd5,`L_HI`}, `conflict`=1.
- Drive {`S_STRONG`,`L_HI`}, then all off with D=16 -> edges 1..15 show {`CHARGE_S`,`L_HI`} and `floating`=0; edge 16 shows {`S_OFF`,`L_LO`} and `floating`=1.
- Drive `L_HI`, go undriven 8 edges, re-drive {3'd5,`L_LO`} one edge, go undriven again -> the counter restarts, with 15 further charge cycles at `L_LO`. `DECAY_CYCLES`=0 variant holds `L_HI` charge for 1000 edges.
- Assert `reset` on undriven edge 7 of a decay -> next cycle `net_out`={`S_OFF`,`L_LO`}, `floating`=1; charge is not restored when `reset` drops.
